// File: rtl/led_pattern_engine.sv
// LED pattern engine: rotate-left/right, ping-pong and bar-fill patterns stepped by a
// selectable prescaler. Define LED_PWM_DIM_EN to add a duty input that dims the LEDs with PWM.
module led_pattern_engine #(
    parameter int N_LED = 8,
    parameter int CNT_W = 20,
    parameter int DIV0  = 999,
    parameter int DIV1  = 1999,
    parameter int DIV2  = 4999,
    parameter int DIV3  = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic [1:0]       freq_set,
`ifdef LED_PWM_DIM_EN
    input  logic [3:0]       duty,
`endif
    output logic [N_LED-1:0] led,
    output logic             wrap
);

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

    localparam logic [N_LED-1:0] PAT_LO  = {{(N_LED-1){1'b0}}, 1'b1};
    localparam logic [N_LED-1:0] PAT_HI  = {1'b1, {(N_LED-1){1'b0}}};
    localparam logic [CNT_W-1:0] LIM0    = CNT_W'(DIV0);
    localparam logic [CNT_W-1:0] LIM1    = CNT_W'(DIV1);
    localparam logic [CNT_W-1:0] LIM2    = CNT_W'(DIV2);
    localparam logic [CNT_W-1:0] LIM3    = CNT_W'(DIV3);

    logic [CNT_W-1:0] cnt, cnt_n, limit;
    logic [N_LED-1:0] pattern, pat_n, step_pat;
    logic [1:0]       mode_q, mode_n;
    dir_t             dir, dir_n, step_dir;
    logic             wrap_n, step_wrap, tick;

    function automatic logic [N_LED-1:0] start_of(input logic [1:0] m);
        case (m)
            2'b01:   return PAT_HI;
            2'b11:   return '0;
            default: return PAT_LO;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            mode_q  <= 2'b00;
            dir     <= DIR_UP;
            pattern <= PAT_LO;
            wrap    <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            mode_q  <= mode_n;
            dir     <= dir_n;
            pattern <= pat_n;
            wrap    <= wrap_n;
        end
    end

    always_comb begin
        case (freq_set)
            2'd0:    limit = LIM0;
            2'd1:    limit = LIM1;
            2'd2:    limit = LIM2;
            default: limit = LIM3;
        endcase
        // >= so that lowering the limit mid-count ticks at once instead of wrapping
        tick = (cnt >= limit);

        step_pat = pattern;
        step_dir = dir;
        case (mode_q)
            2'b00: step_pat = {pattern[N_LED-2:0], pattern[N_LED-1]};
            2'b01: step_pat = {pattern[0], pattern[N_LED-1:1]};
            2'b10: begin
                // direction flips on arrival at an end, so each end LED is lit for one tick
                if (dir == DIR_UP) begin
                    step_pat = pattern << 1;
                    if (step_pat[N_LED-1]) step_dir = DIR_DOWN;
                end else begin
                    step_pat = pattern >> 1;
                    if (step_pat[0]) step_dir = DIR_UP;
                end
            end
            default: step_pat = (&pattern) ? '0 : {pattern[N_LED-2:0], 1'b1};
        endcase
        step_wrap = (step_pat == start_of(mode_q)) &&
                    ((mode_q != 2'b10) || (step_dir == DIR_UP));

        cnt_n  = cnt;
        pat_n  = pattern;
        dir_n  = dir;
        mode_n = mode_q;
        wrap_n = 1'b0;
        if (clear || (mode != mode_q)) begin
            cnt_n  = '0;
            pat_n  = start_of(mode);
            dir_n  = DIR_UP;
            mode_n = mode;
        end else if (run) begin
            if (tick) begin
                cnt_n  = '0;
                pat_n  = step_pat;
                dir_n  = step_dir;
                wrap_n = step_wrap;
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= 4'd0;
            led     <= PAT_LO;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            led     <= pattern & {N_LED{pwm_cnt < duty}};
        end
    end
`else
    assign led = pattern;
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine: N_LED=8 with small dividers so every pattern
// period, pause/clear, divider change, mode switch and async reset fit in a short run.
module tb_led_pattern_engine;

    localparam int N_LED = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run = 1'b1;
    logic             clear = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [1:0]       freq_set = 2'd0;
    logic [N_LED-1:0] led;
    logic             wrap;
`ifdef LED_PWM_DIM_EN
    logic [3:0]       duty = 4'd4;
`endif

    int vec_count = 0;
    int miscompare_count = 0;

    led_pattern_engine #(
        .N_LED(N_LED), .CNT_W(20), .DIV0(3), .DIV1(1), .DIV2(9), .DIV3(99)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .clear(clear),
        .mode(mode),
        .freq_set(freq_set),
`ifdef LED_PWM_DIM_EN
        .duty(duty),
`endif
        .led(led),
        .wrap(wrap)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompare_count++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        int m;
        int pos;
        int exp_v;

        step(2);
        check("reset_led", led, 32'h01);
        check("reset_wrap", wrap, 0);
        rst = 1'b0;

`ifndef LED_PWM_DIM_EN
        // rotate-left, tick every 4 clocks
        for (int k = 1; k <= 8; k++) begin
            step(4);
            check("rotl_led", led, 32'(1 << (k % 8)));
            check("rotl_wrap", wrap, (k == 8) ? 1 : 0);
        end
        step(1);
        check("rotl_wrap_low", wrap, 0);

        // clear, then switch to rotate-right at led=10
        clear = 1'b1;
        step(1);
        check("clear_led", led, 32'h01);
        clear = 1'b0;
        step(16);
        check("rotl_at_10", led, 32'h10);
        mode = 2'b01;
        step(1);
        check("switch_led", led, 32'h80);
        check("switch_wrap", wrap, 0);
        step(4);
        check("rotr_led", led, 32'h40);

        // pause mid-count, then resume from the held count
        step(2);
        run = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            check("pause_led", led, 32'h40);
            check("pause_wrap", wrap, 0);
        end
        run = 1'b1;
        step(1);
        check("resume_hold", led, 32'h40);
        step(1);
        check("resume_tick", led, 32'h20);

        // clear while paused zeroes the count
        step(2);
        run = 1'b0;
        clear = 1'b1;
        mode = 2'b00;
        step(1);
        check("clear_pause_led", led, 32'h01);
        check("clear_pause_wrap", wrap, 0);
        clear = 1'b0;
        run = 1'b1;
        step(3);
        check("clear_cnt0_hold", led, 32'h01);
        step(1);
        check("clear_cnt0_tick", led, 32'h02);

        // ping-pong, tick every 2 clocks, period 14 ticks
        mode = 2'b10;
        freq_set = 2'd1;
        step(1);
        check("pp_load", led, 32'h01);
        check("pp_load_wrap", wrap, 0);
        for (int k = 1; k <= 16; k++) begin
            step(2);
            m = k % 14;
            pos = (m <= 7) ? m : 14 - m;
            check("pp_led", led, 32'(1 << pos));
            check("pp_wrap", wrap, (m == 0) ? 1 : 0);
        end

        // bar-fill, period 9 ticks
        mode = 2'b11;
        step(1);
        check("bar_load", led, 32'h00);
        check("bar_load_wrap", wrap, 0);
        for (int k = 1; k <= 10; k++) begin
            step(2);
            m = k % 9;
            exp_v = (1 << m) - 1;
            check("bar_led", led, 32'(exp_v));
            check("bar_wrap", wrap, (m == 0) ? 1 : 0);
        end

        // divider drop mid-count ticks at once
        mode = 2'b00;
        freq_set = 2'd3;
        step(1);
        check("div_load", led, 32'h01);
        step(50);
        check("div_cnt50", led, 32'h01);
        freq_set = 2'd2;
        step(1);
        check("div_drop_tick", led, 32'h02);
        step(9);
        check("div_hold", led, 32'h02);
        step(1);
        check("div_next_tick", led, 32'h04);

        // async reset between edges
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_led", led, 32'h01);
        check("async_rst_wrap", wrap, 0);
        @(negedge clk);
        rst = 1'b0;
        freq_set = 2'd0;
        step(3);
        check("post_rst_hold", led, 32'h01);
        step(1);
        check("post_rst_tick", led, 32'h02);
`else
        // PWM dimming: count lit clocks over one 16-clock PWM period
        for (int d = 0; d < 3; d++) begin
            duty = (d == 0) ? 4'd4 : (d == 1) ? 4'd0 : 4'd15;
            step(2);
            exp_v = 0;
            for (int k = 0; k < 16; k++) begin
                step(1);
                if (led != '0) exp_v++;
            end
            check("pwm_lit", 32'(exp_v), 32'(duty));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end

endmodule
